nes_pad_poller: RTL
===================

// Module: nes_pad_poller
// PURPOSE
// Parametrised serial game-pad poller for NES (8-bit) and SNES (16-bit) pads.
// Scans NUM_PADS pads in parallel over one shared latch and one shared pad clock.
// Each pad has its own data line. Runs from the system clock through a
// programmable phase timer. Publishes debounced-by-frame button vectors, a
// per-poll valid strobe and one-cycle press-edge flags to game logic.
// PARAMETERS
// NUM_PADS     2    number of pads, each with its own data line (1..4)
// BITS         8    serial bits per pad: 8 = NES, 16 = SNES
// HALF_PERIOD  300  system clocks per pad-clock half phase (>=4; 300 = 6 us @ 50 MHz)
// POLL_PERIOD  0    clocks between automatic polls; 0 = poll only on poll_req
// PORTS
// clock        in   1               system clock; all logic on posedge
// reset        in   1               synchronous, active-high reset
// poll_req     in   1               one-cycle request to start a scan
// data_in      in   NUM_PADS        raw pad data lines, active-low, asynchronous
// latch        out  1               pad latch, shared by all pads
// pad_clock    out  1               pad shift clock, shared by all pads
// busy         out  1               high while a scan is in progress
// buttons      out  NUM_PADS*BITS   pressed=1; bit p*BITS+i = serial bit i of pad p
// pressed      out  NUM_PADS*BITS   one-cycle rising edges of buttons
// valid        out  1               one-cycle strobe; buttons/pressed updated this cycle
// BEHAVIOUR
// - Reset: every output = 0; FSM=IDLE; shift regs, synchronisers, phase and poll counters = 0; pending=0.
// - data_in passes through a 2-flop synchroniser. Sampled bits are inverted, so low on the line = pressed.
// - FSM states: IDLE -> LATCH -> BIT_LO -> BIT_HI -> ... -> DONE -> IDLE.
//   - IDLE: latch=0, pad_clock=0, busy=0. Start on poll_req | pending.
//   - LATCH: latch=1 for 2*HALF_PERIOD clocks. busy=1 from this state until DONE.
//   - BIT_LO(i): pad_clock=0 for HALF_PERIOD clocks. On its last clock, shift the inverted synced data_in[p] into bit i of the shadow reg for every pad p.
//   - BIT_HI(i): pad_clock=1 for HALF_PERIOD clocks, then i+1. After bit BITS-1 there is no BIT_HI; go straight to DONE.
//   - DONE: one clock. buttons <= shadow. pressed <= shadow & ~buttons_old. valid=1.
// - Outputs while scanning:
//   - pressed and valid are 0 in every cycle except DONE.
//   - buttons holds its last value through the scan and updates atomically in DONE.
// - Latency: poll_req high in cycle t (IDLE) -> valid in cycle t+1+(2*BITS+1)*HALF_PERIOD.
// - Bit order: serial bit 0 (NES A / SNES B) is first. SNES bits 12-15 report whatever the pad drives.
// - Auto-poll (POLL_PERIOD>0):
//   - A free-running counter wraps every POLL_PERIOD clocks and produces a tick.
//   - A tick while busy sets pending; the scan runs on return to IDLE. At most one pending.
//   - pending clears when the scan starts.
// - poll_req while busy is dropped (not queued). Same-cycle poll_req and tick start one scan.
// - Disconnected pad: the line floats high and reads all-released (0s). No error flag.
// - Reset mid-scan:
//   - abort on the next edge; latch and pad_clock drop to 0;
//   - buttons cleared; no valid strobe.
// - Counters wrap-free: the phase counter clears on every state change.
//   Width is $clog2(2*HALF_PERIOD).
// TESTING
// 1 Reset check (HALF_PERIOD=4, NUM_PADS=2). Assert reset 3 cycles
//   -> all outputs 0; latch=pad_clock=0 for 20 cycles with no poll_req.
// 2 Single scan, BITS=8. poll_req at t; pad0 line drives A,Start low, pad1 drives Right low
//   -> latch high t+1..t+8; 8 pad_clock low phases and 7 high phases;
//   -> valid at t+69; buttons=16'h8009; pressed=16'h8009.
// 3 Second scan, pad0 now only Start low
//   -> buttons=16'h8008; pressed=16'h0000; valid one cycle only.
// 4 poll_req pulsed mid-scan (e.g. t+20)
//   -> ignored; exactly one valid; busy drops after DONE.
// 5 Reset at t+40 mid-scan
//   -> next cycle latch=pad_clock=busy=0, buttons=0; no valid; a fresh poll_req then scans normally.
// 6 BITS=16, POLL_PERIOD=200, HALF_PERIOD=4, tick lands during a scan
//   -> pending scan starts the cycle after DONE; 16 sampled bits per pad;
//   -> valid period 133 clocks between back-to-back scans.

Source files
------------

// File: rtl/nes_pad_poller.sv
// Serial poller for NES/SNES game pads: shared latch and pad clock, one data line per pad.
// Produces frame-debounced button vectors, a per-poll valid strobe and press-edge flags.
module nes_pad_poller #(
  parameter int unsigned NUM_PADS    = 2,
  parameter int unsigned BITS        = 8,
  parameter int unsigned HALF_PERIOD = 300,
  parameter int unsigned POLL_PERIOD = 0
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     poll_req_i,
  input  logic [NUM_PADS-1:0]      data_in_i,
  output logic                     latch_o,
  output logic                     pad_clock_o,
  output logic                     busy_o,
  output logic [NUM_PADS*BITS-1:0] buttons_o,
  output logic [NUM_PADS*BITS-1:0] pressed_o,
  output logic                     valid_o
);

  localparam int unsigned W    = NUM_PADS * BITS;
  localparam int unsigned PhW  = $clog2(2 * HALF_PERIOD);
  localparam int unsigned IdxW = (BITS > 1) ? $clog2(BITS) : 1;

  localparam logic [PhW-1:0]  LatchLast = PhW'(2 * HALF_PERIOD - 1);
  localparam logic [PhW-1:0]  HalfLast  = PhW'(HALF_PERIOD - 1);
  localparam logic [IdxW-1:0] BitLast   = IdxW'(BITS - 1);

  typedef enum logic [2:0] {StIdle, StLatch, StBitLo, StBitHi, StDone} state_e;

  state_e              state_q, state_d;
  logic [PhW-1:0]      phase_q, phase_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [W-1:0]        shadow_q, shadow_d, shifted;
  logic [W-1:0]        buttons_q, pressed_q;
  logic                valid_q;
  logic [NUM_PADS-1:0] sync1_q, sync2_q;
  logic                pending_q, pending_d;
  logic                tick, start, sample, done;

  // Each pad field shifts right; after BITS samples the first bit lands in bit 0.
  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    assign shifted[p*BITS +: BITS] = {~sync2_q[p], shadow_q[p*BITS+1 +: BITS-1]};
  end

  if (POLL_PERIOD > 0) begin : g_auto
    localparam int unsigned PollW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    logic [PollW-1:0] poll_cnt_q, poll_cnt_d;

    assign tick       = (poll_cnt_q == PollW'(POLL_PERIOD - 1));
    assign poll_cnt_d = tick ? '0 : poll_cnt_q + PollW'(1);

    always_ff @(posedge clock_i) begin
      if (reset_i) poll_cnt_q <= '0;
      else         poll_cnt_q <= poll_cnt_d;
    end
  end else begin : g_no_auto
    assign tick = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    start    = 1'b0;
    sample   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (poll_req_i || pending_q || tick) begin
          state_d = StLatch;
          start   = 1'b1;
        end
      end
      StLatch: begin
        if (phase_q == LatchLast) begin
          state_d = StBitLo;
          idx_d   = '0;
        end
      end
      StBitLo: begin
        if (phase_q == HalfLast) begin
          sample  = 1'b1;
          state_d = (idx_q == BitLast) ? StDone : StBitHi;
        end
      end
      StBitHi: begin
        if (phase_q == HalfLast) begin
          state_d = StBitLo;
          idx_d   = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        // A queued poll chains straight into the next scan; poll_req is dropped here.
        if (pending_q || tick) begin
          state_d = StLatch;
          start   = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_d != state_q) || (state_q == StIdle) || (state_q == StDone)) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PhW'(1);
    end

    shadow_d = sample ? shifted : shadow_q;
    done     = sample && (idx_q == BitLast);

    pending_d = pending_q;
    if (start) begin
      pending_d = 1'b0;
    end else if (tick && (state_q != StIdle)) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      buttons_q <= '0;
      pressed_q <= '0;
      valid_q   <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      sync1_q   <= data_in_i;
      sync2_q   <= sync1_q;
      pending_q <= pending_d;
      valid_q   <= done;
      pressed_q <= done ? (shadow_d & ~buttons_q) : '0;
      if (done) buttons_q <= shadow_d;
    end
  end

  assign latch_o     = (state_q == StLatch);
  assign pad_clock_o = (state_q == StBitHi);
  assign busy_o      = (state_q != StIdle);
  assign buttons_o   = buttons_q;
  assign pressed_o   = pressed_q;
  assign valid_o     = valid_q;

endmodule
